// File: rtl/arm_pkg.sv
// Shared ARM-style condition definitions: cond_e encoding, flag bit positions, FlagW groups.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arm_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  // Bit positions of {N,Z,C,V} within the 4-bit flags word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW bit positions: one bit per independently writable flag group.
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/condlogic_if.sv
// Bundles the decoder controls, ALU flags and gated outputs of condlogic.
// Latency: n/a (wiring only). Backpressure: none, every signal is level-based.
// slave modport = condlogic side, master modport = decoder/bench side.
interface condlogic_if;

  logic        En;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS;
  logic        RegW;
  logic        MemW;
  logic        NoWrite;

  logic        PCSrc;
  logic        RegWrite;
  logic        MemWrite;
  logic        CondEx;
  logic [3:0]  Flags;
  logic [31:0] ExecCount;
  logic [31:0] SquashCount;

  modport slave (
    input  En, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SquashCount
  );

  modport master (
    output En, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SquashCount
  );

endinterface

// File: rtl/condcheck.sv
// Evaluates an instruction condition field against the architectural flags.
// Latency: purely combinational. Backpressure: none.
// Ports: Cond (condition field), Flags ({N,Z,C,V}) -> CondEx (condition passes).
module condcheck
  import arm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_ge;

  assign w_n  = Flags[FLAG_N];
  assign w_z  = Flags[FLAG_Z];
  assign w_c  = Flags[FLAG_C];
  assign w_v  = Flags[FLAG_V];
  assign w_ge = (w_n == w_v);

  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      EQ: CondEx = w_z;
      NE: CondEx = ~w_z;
      CS: CondEx = w_c;
      CC: CondEx = ~w_c;
      MI: CondEx = w_n;
      PL: CondEx = ~w_n;
      VS: CondEx = w_v;
      VC: CondEx = ~w_v;
      HI: CondEx = w_c & ~w_z;
      LS: CondEx = ~w_c | w_z;
      GE: CondEx = w_ge;
      LT: CondEx = ~w_ge;
      GT: CondEx = ~w_z & w_ge;
      LE: CondEx = w_z | ~w_ge;
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution unit: gates PCS/RegW/MemW on the condition and owns the {N,Z,C,V} register.
// Latency: gated outputs are combinational; flag writes become visible one cycle after the update edge.
// Backpressure: none; En only qualifies state updates, never the gated outputs.
// Ports: clk, reset_n (async active-low), bus (condlogic_if.slave).
// Build option CONDLOGIC_STATS_EN adds saturating ExecCount/SquashCount; otherwise both read 0.
module condlogic
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  condlogic_if.slave bus
);

  logic       w_cond_ex;
  logic       w_update;
  logic [3:0] r_flags;

  // Condition is judged on the registered flags so a flag-setting instruction
  // never affects its own predicate.
  condcheck u_condcheck (
    .Cond   (bus.Cond),
    .Flags  (r_flags),
    .CondEx (w_cond_ex)
  );

  assign w_update = bus.En & w_cond_ex;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= 4'b0000;
    end else if (w_update) begin
      if (bus.FlagW[FLAGW_NZ]) begin
        r_flags[FLAG_N] <= bus.ALUFlags[FLAG_N];
        r_flags[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
      end
      if (bus.FlagW[FLAGW_CV]) begin
        r_flags[FLAG_C] <= bus.ALUFlags[FLAG_C];
        r_flags[FLAG_V] <= bus.ALUFlags[FLAG_V];
      end
    end
  end

  assign bus.CondEx   = w_cond_ex;
  assign bus.Flags    = r_flags;
  assign bus.PCSrc    = bus.PCS & w_cond_ex;
  assign bus.RegWrite = bus.RegW & w_cond_ex & ~bus.NoWrite;
  assign bus.MemWrite = bus.MemW & w_cond_ex;

`ifdef CONDLOGIC_STATS_EN
  logic [31:0] r_exec_count;
  logic [31:0] r_squash_count;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exec_count   <= 32'd0;
      r_squash_count <= 32'd0;
    end else if (bus.En) begin
      if (w_cond_ex) begin
        if (r_exec_count != 32'hFFFF_FFFF) r_exec_count <= r_exec_count + 32'd1;
      end else begin
        if (r_squash_count != 32'hFFFF_FFFF) r_squash_count <= r_squash_count + 32'd1;
      end
    end
  end

  assign bus.ExecCount   = r_exec_count;
  assign bus.SquashCount = r_squash_count;
`else
  assign bus.ExecCount   = 32'd0;
  assign bus.SquashCount = 32'd0;
`endif

endmodule

// File: tb/tb_condlogic.sv
// Self-checking bench for condlogic: directed vector table, condition sweep, async reset and counter corners.
module tb_condlogic;

`ifdef CONDLOGIC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       en, pcs, regw, memw, nowrite, tick;
    logic [3:0] e_flags;
    logic       e_condex, e_pcsrc, e_regwrite, e_memwrite;
  } vec_t;

  typedef struct {
    logic [3:0]  flags;
    logic        condex, pcsrc, regwrite, memwrite;
    logic [31:0] exec, squash;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  condlogic_if bus();

  condlogic dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [31:0] m_exec   = 32'd0;
  logic [31:0] m_squash = 32'd0;

  vec_t        dir[14];
  logic [3:0]  pats[5];
  logic [15:0] masks[5];
  logic [3:0]  cur_flags;
  logic [15:0] mk_mask;

  function automatic vec_t mk(input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] flagw,
                              input logic en, input logic pcs, input logic regw, input logic memw,
                              input logic nowrite, input logic tick, input logic [3:0] e_flags,
                              input logic e_condex, input logic e_pcsrc, input logic e_regwrite,
                              input logic e_memwrite);
    vec_t v;
    v.cond = cond; v.alu = alu; v.flagw = flagw; v.en = en; v.pcs = pcs; v.regw = regw;
    v.memw = memw; v.nowrite = nowrite; v.tick = tick; v.e_flags = e_flags;
    v.e_condex = e_condex; v.e_pcsrc = e_pcsrc; v.e_regwrite = e_regwrite; v.e_memwrite = e_memwrite;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty got 0 entries expected 1", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".Flags"},       {28'd0, bus.Flags},    {28'd0, e.flags});
      check({tag, ".CondEx"},      {31'd0, bus.CondEx},   {31'd0, e.condex});
      check({tag, ".PCSrc"},       {31'd0, bus.PCSrc},    {31'd0, e.pcsrc});
      check({tag, ".RegWrite"},    {31'd0, bus.RegWrite}, {31'd0, e.regwrite});
      check({tag, ".MemWrite"},    {31'd0, bus.MemWrite}, {31'd0, e.memwrite});
      check({tag, ".ExecCount"},   bus.ExecCount,         e.exec);
      check({tag, ".SquashCount"}, bus.SquashCount,       e.squash);
    end
  endtask

  // Entered and left at posedge+1; a vector without tick drops En before the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    bus.Cond = v.cond; bus.ALUFlags = v.alu; bus.FlagW = v.flagw; bus.En = v.en;
    bus.PCS = v.pcs; bus.RegW = v.regw; bus.MemW = v.memw; bus.NoWrite = v.nowrite;
    e.flags = v.e_flags; e.condex = v.e_condex; e.pcsrc = v.e_pcsrc;
    e.regwrite = v.e_regwrite; e.memwrite = v.e_memwrite;
    e.exec   = STATS ? m_exec   : 32'd0;
    e.squash = STATS ? m_squash : 32'd0;
    sb.push_back(e);
    #2;
    sample(tag);
    if (v.tick) begin
      if (v.en && reset_n) begin
        if (v.e_condex) begin
          if (m_exec != 32'hFFFF_FFFF) m_exec = m_exec + 32'd1;
        end else begin
          if (m_squash != 32'hFFFF_FFFF) m_squash = m_squash + 32'd1;
        end
      end
    end else begin
      bus.En = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    // cond alu flagw en pcs regw memw nowr tick | flags condex pcsrc regwrite memwrite
    dir[0]  = mk(4'h0, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    dir[1]  = mk(4'h1, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0);
    dir[2]  = mk(4'h0, 4'b0100, 2'b11, 1, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
    dir[3]  = mk(4'hE, 4'b0100, 2'b11, 1, 0, 0, 0, 0, 1, 4'b0000, 1, 0, 0, 0);
    dir[4]  = mk(4'h0, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 0, 4'b0100, 1, 0, 0, 1);
    dir[5]  = mk(4'h1, 4'b1010, 2'b11, 1, 0, 1, 0, 0, 1, 4'b0100, 0, 0, 0, 0);
    dir[6]  = mk(4'hE, 4'b0000, 2'b00, 1, 0, 1, 0, 0, 1, 4'b0100, 1, 0, 1, 0);
    dir[7]  = mk(4'hE, 4'b0000, 2'b11, 1, 0, 1, 0, 1, 1, 4'b0100, 1, 0, 0, 0);
    dir[8]  = mk(4'hE, 4'b1111, 2'b10, 1, 1, 0, 0, 0, 1, 4'b0000, 1, 1, 0, 0);
    dir[9]  = mk(4'hE, 4'b0011, 2'b01, 1, 0, 0, 0, 0, 1, 4'b1100, 1, 0, 0, 0);
    dir[10] = mk(4'hE, 4'b0000, 2'b00, 0, 0, 1, 0, 1, 0, 4'b1111, 1, 0, 0, 0);
    dir[11] = mk(4'hE, 4'b0000, 2'b11, 0, 1, 0, 0, 0, 1, 4'b1111, 1, 1, 0, 0);
    dir[12] = mk(4'hF, 4'b0000, 2'b11, 1, 1, 1, 1, 0, 1, 4'b1111, 0, 0, 0, 0);
    dir[13] = mk(4'h0, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 0, 4'b1111, 1, 0, 0, 1);

    // Bit c of each mask is the expected CondEx for Cond=c under the paired flags.
    pats[0] = 4'b0000; masks[0] = 16'h56AA;
    pats[1] = 4'b0100; masks[1] = 16'h66A9;
    pats[2] = 4'b1001; masks[2] = 16'h565A;
    pats[3] = 4'b0010; masks[3] = 16'h55A6;
    pats[4] = 4'b1000; masks[4] = 16'h6A9A;

    reset_n = 1'b0;
    bus.En = 1'b0; bus.Cond = 4'h0; bus.ALUFlags = 4'h0; bus.FlagW = 2'b00;
    bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.NoWrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Outputs while held in reset.
    apply(mk(4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0), "rst_eq");
    apply(mk(4'h1, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0), "rst_ne");
    apply(mk(4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 0, 0, 4'b0000, 1, 0, 0, 1), "rst_al");
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) apply(dir[i], $sformatf("dir%0d", i));
    check("exec_after_table",   bus.ExecCount,   STATS ? 32'd5 : 32'd0);
    check("squash_after_table", bus.SquashCount, STATS ? 32'd3 : 32'd0);

    cur_flags = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      apply(mk(4'hE, pats[p], 2'b11, 1, 0, 0, 0, 0, 1, cur_flags, 1, 0, 0, 0), $sformatf("load%0d", p));
      cur_flags = pats[p];
      mk_mask = masks[p];
      for (int c = 0; c < 16; c++) begin
        apply(mk(c[3:0], 4'h0, 2'b00, 0, 1, 1, 0, 0, 0, cur_flags,
                 mk_mask[c], mk_mask[c], mk_mask[c], 1'b0),
              $sformatf("sweep%0d_c%0h", p, c));
      end
    end

    // Reset dropped between edges while an update is pending.
    bus.Cond = 4'hE; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111; bus.En = 1'b1;
    bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.NoWrite = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_flags",  {28'd0, bus.Flags}, 32'd0);
    check("async_rst_exec",   bus.ExecCount,      32'd0);
    check("async_rst_squash", bus.SquashCount,    32'd0);
    m_exec = 32'd0;
    m_squash = 32'd0;
    @(posedge clk);
    #1;
    apply(mk(4'hE, 4'b1111, 2'b11, 1, 0, 0, 0, 0, 1, 4'b0000, 1, 0, 0, 0), "inrst_upd");
    apply(mk(4'h0, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0), "inrst_hold");
    reset_n = 1'b1;
    apply(mk(4'hE, 4'b1111, 2'b11, 1, 0, 0, 0, 0, 1, 4'b0000, 1, 0, 0, 0), "post_rst_upd");
    apply(mk(4'h0, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 4'b1111, 1, 1, 0, 0), "post_rst_eq");

`ifdef CONDLOGIC_STATS_EN
    force dut.r_exec_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_exec_count;
    m_exec = 32'hFFFF_FFFF;
    apply(mk(4'hE, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 1, 4'b1111, 1, 0, 0, 0), "sat_pre");
    apply(mk(4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 4'b1111, 1, 0, 0, 0), "sat_post");
    check("sat_exec", bus.ExecCount, 32'hFFFF_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/condlogic.md
CONDLOGIC -- requirements
Module: condlogic

Interface
REQ-001 The module SHALL have no parameters; all widths SHALL be fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 En  input  1  instruction-advance qualifier; state SHALL update only while high.
REQ-005 Cond  input  4  condition field of the current instruction.
REQ-006 ALUFlags  input  4  {N,Z,C,V} in bits [3:0], from the ALU of the current instruction.
REQ-007 FlagW  input  2  flag-write request; [1] selects N,Z and [0] selects C,V.
REQ-008 PCS, RegW, MemW, NoWrite  input  1 each  unconditioned decoder controls.
REQ-009 PCSrc, RegWrite, MemWrite  output  1 each  condition-gated controls.
REQ-010 CondEx  output  1  high when the current instruction's condition passes.
REQ-011 Flags  output  4  current architectural {N,Z,C,V} register.
REQ-012 ExecCount, SquashCount  output  32 each  statistics counters (see Configuration).

Function
REQ-013 CondEx SHALL be combinational from Cond and the registered Flags, never from ALUFlags.
REQ-014 Cond decode SHALL be: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V); E AL 1; F 0.
REQ-015 PCSrc SHALL equal PCS&CondEx, RegWrite SHALL equal RegW&CondEx&~NoWrite, and MemWrite SHALL equal MemW&CondEx, all with zero-cycle latency.
REQ-016 On a rising clk with En=1 and CondEx=1, Flags[3:2] SHALL load ALUFlags[3:2] if FlagW[1]=1, and Flags[1:0] SHALL load ALUFlags[1:0] if FlagW[0]=1.
REQ-017 A flag group not selected, or any update with CondEx=0 or En=0, SHALL leave Flags unchanged.
REQ-018 New flags SHALL become visible to CondEx in the cycle after the update, never in the same cycle.
REQ-019 Output gating SHALL ignore En; En SHALL affect only state updates.

Reset
REQ-020 When reset_n falls, Flags SHALL clear to 4'b0000 immediately, independent of clk.
REQ-021 When reset_n falls, both counters SHALL clear to 0 immediately, independent of clk.
REQ-022 While reset_n=0, all state SHALL hold at reset values; the outputs SHALL reflect cleared Flags (EQ fails, NE passes, AL passes).
REQ-023 Reset asserted mid-instruction SHALL discard any pending flag update.
REQ-024 The first rising edge after release SHALL behave as a normal update.

Configuration
REQ-025 Macro CONDLOGIC_STATS_EN SHALL control the statistics counters.
REQ-026 With CONDLOGIC_STATS_EN defined, each rising edge with En=1 SHALL increment ExecCount if CondEx=1, otherwise SquashCount.
REQ-027 Both counters SHALL saturate at 32'hFFFFFFFF and SHALL NOT wrap.
REQ-028 With CONDLOGIC_STATS_EN undefined, no counter flops SHALL be built and ExecCount and SquashCount SHALL be tied to 0.
REQ-029 All other behaviour SHALL be identical whether or not CONDLOGIC_STATS_EN is defined.

Structure
REQ-030 Shared package arm_pkg SHALL hold the cond_e enum (EQ..NV, 4-bit), flag bit-index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), and the FlagW group constants.
REQ-031 Condition evaluation SHALL be a purely combinational sub-module condcheck (Cond, Flags -> CondEx), instantiated once.
REQ-032 Flag and counter registers SHALL live in condlogic.

Verification
REQ-033 Reset then Cond=0 (EQ), PCS=1: PCSrc=0 and Flags=0000; Cond=1 (NE) then gives PCSrc=1.
REQ-034 Cond=E, FlagW=11, ALUFlags=0100, edge: Flags=0100, and Cond=0 in the next cycle gives CondEx=1; in the same cycle as the write, CondEx uses the old flags.
REQ-035 Flags=0100, Cond=1, FlagW=11, ALUFlags=1010, RegW=1, edge: RegWrite=0 and Flags stay 0100.
REQ-036 Flags=0000, Cond=E, FlagW=10, ALUFlags=1111, edge: Flags=1100; then FlagW=01, ALUFlags=0011, edge: Flags=1111; NoWrite=1 with RegW=1 gives RegWrite=0.
REQ-037 Sweep Cond 0..F against Flags {0000, 0100, 1001, 0010, 1000}: CondEx matches the REQ-014 table; En=0 with FlagW=11 leaves Flags unchanged.
REQ-038 With CONDLOGIC_STATS_EN defined, 5 passing and 3 failing instructions give ExecCount=5 and SquashCount=3; a counter forced to FFFFFFFF stays FFFFFFFF; reset_n pulsed low between clk edges clears both counters and Flags at once.
